// File: rtl/layer_compositor_if.sv
// Pixel, configuration and result signals that pass between the object drawers,
// the layer compositor and the VGA output stage.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 10,
  parameter int COLOR_W    = 8
);
  localparam int LW = $clog2(NUM_LAYERS);

  logic                          startOfFrame;
  logic [NUM_LAYERS-1:0]         layerDR;
  logic [NUM_LAYERS*COLOR_W-1:0] layerRGB;
  logic [COLOR_W-1:0]            backgroundRGB;
  logic                          cfgWrite;
  logic [LW-1:0]                 cfgLayer;
  logic [1:0]                    cfgMode;
  logic [COLOR_W-1:0]            RGBOut;
  logic [LW-1:0]                 hitLayer;
  logic                          hitValid;

  modport master (
    output startOfFrame, layerDR, layerRGB, backgroundRGB, cfgWrite, cfgLayer, cfgMode,
    input  RGBOut, hitLayer, hitValid
  );

  modport slave (
    input  startOfFrame, layerDR, layerRGB, backgroundRGB, cfgWrite, cfgLayer, cfgMode,
    output RGBOut, hitLayer, hitValid
  );
endinterface

// File: rtl/layer_compositor.sv
// N-layer priority compositor: lowest-index visible layer wins, with per-layer
// hide/blink/flash modes double-buffered to the frame boundary. Two-clock latency.
module layer_compositor #(
  parameter int                 NUM_LAYERS   = 10,
  parameter int                 COLOR_W      = 8,
  parameter logic [COLOR_W-1:0] TRANSPARENT  = 8'hFF,
  parameter int                 BLINK_FRAMES = 16
) (
  input logic               clk,
  input logic               resetN,
  layer_compositor_if.slave bus
);
  localparam int LW = $clog2(NUM_LAYERS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_HIDDEN = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_FLASH  = 2'd3;

  logic [NUM_LAYERS-1:0][1:0] pending_q, pending_nxt;
  logic [NUM_LAYERS-1:0][1:0] active_q, active_nxt;
  logic [FW-1:0]              frame_cnt_q, frame_cnt_nxt;
  logic                       blink_q, blink_nxt;

  logic [NUM_LAYERS-1:0]         dr_p1;
  logic [NUM_LAYERS*COLOR_W-1:0] rgb_p1;
  logic [COLOR_W-1:0]            bg_p1;
  logic [NUM_LAYERS-1:0][1:0]    mode_p1;
  logic                          phase_p1;

  logic [NUM_LAYERS-1:0] elig_p1;
  logic [LW-1:0]         win_p1;
  logic                  hit_p1;
  logic [COLOR_W-1:0]    pix_p1;

  logic [COLOR_W-1:0] rgb_p2;
  logic [LW-1:0]      layer_p2;
  logic               hit_p2;

  function automatic logic [COLOR_W-1:0] flash_color(input logic [COLOR_W-1:0] c,
                                                     input logic invert);
    return invert ? ~c : c;
  endfunction

  // The next-state mode/phase values feed stage 1 so the pixel sampled with
  // startOfFrame (and a write landing on it) already sees the new frame's settings.
  always_comb begin
    pending_nxt   = pending_q;
    frame_cnt_nxt = frame_cnt_q;
    blink_nxt     = blink_q;
    if (bus.cfgWrite && (int'(bus.cfgLayer) < NUM_LAYERS))
      pending_nxt[bus.cfgLayer] = bus.cfgMode;
    active_nxt = bus.startOfFrame ? pending_nxt : active_q;
    if (bus.startOfFrame) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_nxt = '0;
        blink_nxt     = ~blink_q;
      end else begin
        frame_cnt_nxt = frame_cnt_q + FW'(1);
      end
    end
  end

  // Stage 1 -> 2 boundary: eligibility, priority encode and colour select
  always_comb begin
    elig_p1 = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      elig_p1[i] = dr_p1[i]
                && (rgb_p1[i*COLOR_W +: COLOR_W] != TRANSPARENT)
                && (mode_p1[i] != MODE_HIDDEN)
                && !((mode_p1[i] == MODE_BLINK) && !phase_p1);
  end

  always_comb begin
    win_p1 = '0;
    hit_p1 = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (elig_p1[i]) begin
        win_p1 = LW'(i);
        hit_p1 = 1'b1;
      end
    end
    pix_p1 = hit_p1 ? flash_color(rgb_p1[win_p1*COLOR_W +: COLOR_W],
                                  (mode_p1[win_p1] == MODE_FLASH) && !phase_p1)
                    : bg_p1;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      pending_q   <= {NUM_LAYERS{MODE_NORMAL}};
      active_q    <= {NUM_LAYERS{MODE_NORMAL}};
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
      dr_p1       <= '0;
      rgb_p1      <= '0;
      bg_p1       <= '0;
      mode_p1     <= '0;
      phase_p1    <= 1'b0;
      rgb_p2      <= '0;
      layer_p2    <= '0;
      hit_p2      <= 1'b0;
    end else begin
      pending_q   <= pending_nxt;
      active_q    <= active_nxt;
      frame_cnt_q <= frame_cnt_nxt;
      blink_q     <= blink_nxt;
      // Stage 1: input pixel plus the mode/phase it must be judged with
      dr_p1       <= bus.layerDR;
      rgb_p1      <= bus.layerRGB;
      bg_p1       <= bus.backgroundRGB;
      mode_p1     <= active_nxt;
      phase_p1    <= blink_nxt;
      // Stage 2: registered composited pixel
      rgb_p2      <= pix_p1;
      layer_p2    <= win_p1;
      hit_p2      <= hit_p1;
    end
  end

  assign bus.RGBOut   = rgb_p2;
  assign bus.hitLayer = layer_p2;
  assign bus.hitValid = hit_p2;
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: frame-level model scoreboard checked every
// cycle, plus literal expectations for reset, priority, buffering, blink and flash.
module tb_layer_compositor;
  localparam int NL = 10;
  localparam int CW = 8;
  localparam int BF = 2;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

  layer_compositor #(
    .NUM_LAYERS(NL), .COLOR_W(CW), .TRANSPARENT(8'hFF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: modes as plain arrays, blink phase derived from the number of frames seen.
  int                  pend [NL];
  int                  act  [NL];
  int                  sofs;
  logic                vis, found;
  logic [CW-1:0]       c;
  logic [CW+LW:0]      e_prev = '0;
  logic [CW+LW:0]      e_last = '0;

  always @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NL; i++) begin
        pend[i] = 0;
        act[i]  = 0;
      end
      sofs   = 0;
      e_prev = '0;
      e_last = '0;
    end else begin
      e_prev = e_last;
      if (bus.cfgWrite && int'(bus.cfgLayer) < NL) pend[bus.cfgLayer] = int'(bus.cfgMode);
      if (bus.startOfFrame) begin
        act  = pend;
        sofs = sofs + 1;
      end
      vis    = ((sofs / BF) % 2) == 0;
      found  = 1'b0;
      e_last = {bus.backgroundRGB, 4'd0, 1'b0};
      for (int i = 0; i < NL; i++) begin
        c = bus.layerRGB[i*CW +: CW];
        if (!found && bus.layerDR[i] && c != 8'hFF && act[i] != 1 && !(act[i] == 2 && !vis)) begin
          found  = 1'b1;
          e_last = {((act[i] == 3) && !vis) ? ~c : c, LW'(i), 1'b1};
        end
      end
    end
  end

  always @(negedge clk) begin
    total = total + 1;
    if ({bus.RGBOut, bus.hitLayer, bus.hitValid} !== e_prev) begin
      bad = bad + 1;
      $display("FAIL pix @%0t rgb/layer/vld got %h/%0d/%0d want %h/%0d/%0d", $time,
               bus.RGBOut, bus.hitLayer, bus.hitValid,
               e_prev[CW+LW:LW+1], e_prev[LW:1], e_prev[0]);
    end
  end

  task automatic chk(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("FAIL %s got %h want %h", name, actual, expected);
    end
  endtask

  task automatic set_rgb(input int i, input logic [CW-1:0] v);
    bus.layerRGB[i*CW +: CW] = v;
  endtask

  // Drive one startOfFrame pixel (optionally with a config write), then check
  // the output produced by that very pixel.
  task automatic frame_pixel(input logic wr, input logic [LW-1:0] lyr, input logic [1:0] md);
    bus.startOfFrame = 1'b1;
    bus.cfgWrite     = wr;
    bus.cfgLayer     = lyr;
    bus.cfgMode      = md;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.cfgWrite     = 1'b0;
    @(negedge clk);
  endtask

  logic [CW-1:0] blink_exp [4] = '{8'h55, 8'h00, 8'h00, 8'h55};
  logic          blink_vld [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [CW-1:0] flash_exp [4] = '{8'h0F, 8'hF0, 8'hF0, 8'h0F};

  initial begin
    resetN            = 1'b0;
    bus.startOfFrame  = 1'b0;
    bus.layerDR       = '0;
    bus.layerRGB      = {NL{8'hFF}};
    bus.backgroundRGB = 8'h1C;
    bus.cfgWrite      = 1'b0;
    bus.cfgLayer      = '0;
    bus.cfgMode       = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", bus.RGBOut, 16'h00);
    chk("rst_vld", bus.hitValid, 16'h0);

    resetN = 1'b1;
    @(negedge clk);
    chk("rel1_rgb", bus.RGBOut, 16'h00);
    @(negedge clk);
    chk("bg_rgb", bus.RGBOut, 16'h1C);
    chk("bg_vld", bus.hitValid, 16'h0);

    bus.layerDR = 10'b00_0001_0100;
    set_rgb(2, 8'hE0);
    set_rgb(4, 8'h03);
    repeat (2) @(negedge clk);
    chk("prio_rgb", bus.RGBOut, 16'hE0);
    chk("prio_layer", bus.hitLayer, 16'd2);
    chk("prio_vld", bus.hitValid, 16'h1);
    set_rgb(2, 8'hFF);
    @(negedge clk);
    chk("key_lat1", bus.RGBOut, 16'hE0);
    @(negedge clk);
    chk("key_rgb", bus.RGBOut, 16'h03);
    chk("key_layer", bus.hitLayer, 16'd4);

    set_rgb(2, 8'hE0);
    repeat (2) @(negedge clk);
    bus.cfgWrite = 1'b1;
    bus.cfgLayer = 4'd2;
    bus.cfgMode  = 2'd1;
    @(negedge clk);
    bus.cfgWrite = 1'b0;
    repeat (3) @(negedge clk);
    chk("pend_hold", bus.RGBOut, 16'hE0);
    frame_pixel(1'b0, 4'd0, 2'd0);
    chk("sof_hide_rgb", bus.RGBOut, 16'h03);
    chk("sof_hide_layer", bus.hitLayer, 16'd4);
    repeat (2) @(negedge clk);
    frame_pixel(1'b1, 4'd2, 2'd0);
    chk("sofwr_show", bus.RGBOut, 16'hE0);
    repeat (2) @(negedge clk);
    frame_pixel(1'b1, 4'd2, 2'd1);
    chk("sofwr_hide", bus.RGBOut, 16'h03);
    repeat (2) @(negedge clk);

    resetN = 1'b0;
    @(negedge clk);
    chk("midrst_rgb", bus.RGBOut, 16'h00);
    chk("midrst_vld", bus.hitValid, 16'h0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_normal_rgb", bus.RGBOut, 16'hE0);
    chk("rst_normal_layer", bus.hitLayer, 16'd2);

    bus.layerDR       = 10'b00_0000_0001;
    bus.backgroundRGB = 8'h00;
    set_rgb(0, 8'h55);
    for (int f = 0; f < 4; f++) begin
      frame_pixel(f == 0, 4'd0, 2'd2);
      chk("blink_rgb", bus.RGBOut, 16'(blink_exp[f]));
      chk("blink_vld", bus.hitValid, 16'(blink_vld[f]));
      repeat (2) @(negedge clk);
    end

    set_rgb(0, 8'h0F);
    for (int f = 0; f < 4; f++) begin
      frame_pixel(f == 0, 4'd0, 2'd3);
      chk("flash_rgb", bus.RGBOut, 16'(flash_exp[f]));
      chk("flash_layer", bus.hitLayer, 16'd0);
      chk("flash_vld", bus.hitValid, 16'h1);
      repeat (2) @(negedge clk);
    end

    frame_pixel(1'b1, 4'd10, 2'd1);
    chk("badcfg10_rgb", bus.RGBOut, 16'h0F);
    chk("badcfg10_vld", bus.hitValid, 16'h1);
    repeat (2) @(negedge clk);
    frame_pixel(1'b1, 4'd15, 2'd1);
    chk("badcfg15_rgb", bus.RGBOut, 16'hF0);
    chk("badcfg15_vld", bus.hitValid, 16'h1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
